// File: rtl/mem_arb_pkg.sv
// Shared types for the memory bus arbiter: owner encoding and bus size codes.
// The size codes mirror the core's MEM_SIZE_* defines so this slice is self-contained.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } mem_owner_t;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_dphase.sv
// Data-phase tracker for the memory bus arbiter: remembers who owns the data
// phase of the pipelined bus, steers write data onto the bus and routes read
// data back to that requester only.
module mem_arb_dphase
  import mem_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        accept_i,
  input  mem_owner_t  owner_i,
  input  logic        write_i,
  input  logic        bus_pause_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] bus_wdata_o,
  output logic [31:0] cpu_rdata_o,
  output logic [31:0] dma_rdata_o
);

  logic       dph_valid_q, dph_valid_d;
  mem_owner_t dph_owner_q, dph_owner_d;
  logic       dph_write_q, dph_write_d;

  // Next data phase: advances only when the bus is not frozen.
  always_comb begin
    dph_valid_d = dph_valid_q;
    dph_owner_d = dph_owner_q;
    dph_write_d = dph_write_q;
    if (!bus_pause_i) begin
      dph_valid_d = accept_i;
      if (accept_i) begin
        dph_owner_d = owner_i;
        dph_write_d = write_i;
      end
    end
  end

  // Data-phase registers; reset drops any in-flight transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dph_valid_q <= 1'b0;
      dph_owner_q <= OWN_NONE;
      dph_write_q <= 1'b0;
    end else begin
      dph_valid_q <= dph_valid_d;
      dph_owner_q <= dph_owner_d;
      dph_write_q <= dph_write_d;
    end
  end

  // Write-data mux and read-data demux; idle paths drive zero.
  always_comb begin
    bus_wdata_o = '0;
    cpu_rdata_o = '0;
    dma_rdata_o = '0;
    if (dph_valid_q) begin
      case (dph_owner_q)
        OWN_CPU: begin
          if (dph_write_q) bus_wdata_o = cpu_wdata_i;
          else             cpu_rdata_o = bus_rdata_i;
        end
        OWN_DMA: begin
          if (dph_write_q) bus_wdata_o = dma_wdata_i;
          else             dma_rdata_o = bus_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for the single pipelined mem_top bus port.
// Address-phase ownership is decided combinationally (zero latency) and frozen
// for any cycle that follows a paused cycle. Optional DMA-burst fairness is
// enabled with the MEM_ARB_FAIR_EN macro; without it DMA has strict priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DMA_MAX_BURST = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        dma_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] dma_addr,
  input  logic [1:0]  cpu_size,
  input  logic [1:0]  dma_size,
  input  logic        cpu_write,
  input  logic        dma_write,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  output logic        cpu_pause,
  output logic        dma_pause,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dma_rdata,
  output logic [31:0] bus_addr,
  output logic [1:0]  bus_size,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  input  logic        bus_pause,
  input  logic [31:0] bus_rdata
);

  mem_owner_t  grant_q, grant_d, owner;
  logic        pause_q, pause_d;
  logic        force_cpu;
  logic        own_req, own_write;
  logic [31:0] own_addr;
  logic [1:0]  own_size;
  logic        accept;

`ifdef MEM_ARB_FAIR_EN
  // Counter is 5 bits wide; burst limits above 31 are truncated.
  localparam logic [4:0] BurstMax = 5'(DMA_MAX_BURST);

  logic [4:0] fair_cnt_q, fair_cnt_d;

  // Count back-to-back DMA acceptances, saturating at the burst limit.
  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (accept && (owner == OWN_CPU)) begin
      fair_cnt_d = '0;
    end else if (accept && (owner == OWN_DMA) && (fair_cnt_q < BurstMax)) begin
      fair_cnt_d = fair_cnt_q + 5'd1;
    end
  end

  // Fairness counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fair_cnt_q <= '0;
    else          fair_cnt_q <= fair_cnt_d;
  end

  assign force_cpu = (fair_cnt_q >= BurstMax) & cpu_req & ~dma_lock;
`else
  logic unused_burst;
  assign unused_burst = (DMA_MAX_BURST != 0);
  assign force_cpu    = 1'b0;
`endif

  // Owner selection: hold after a paused cycle, else lock > forced CPU > DMA > CPU.
  always_comb begin
    owner = grant_q;
    if (!reset_n) begin
      owner = OWN_NONE;
    end else if (!pause_q) begin
      if (dma_lock && (grant_q == OWN_DMA)) owner = OWN_DMA;
      else if (force_cpu)                   owner = OWN_CPU;
      else if (dma_req)                     owner = OWN_DMA;
      else if (cpu_req)                     owner = OWN_CPU;
      else                                  owner = OWN_NONE;
    end
  end

  assign grant_d = owner;
  assign pause_d = bus_pause;

  // Owner and previous-pause registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_q <= OWN_NONE;
      pause_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
      pause_q <= pause_d;
    end
  end

  // Address-phase mux from the current owner; idle bus parks at address 0, WORD.
  always_comb begin
    own_req   = 1'b0;
    own_write = 1'b0;
    own_addr  = '0;
    own_size  = MEM_SIZE_WORD;
    case (owner)
      OWN_CPU: begin
        own_req   = cpu_req;
        own_write = cpu_write;
        own_addr  = cpu_addr;
        own_size  = cpu_size;
      end
      OWN_DMA: begin
        own_req   = dma_req;
        own_write = dma_write;
        own_addr  = dma_addr;
        own_size  = dma_size;
      end
      default: ;
    endcase
  end

  assign bus_addr  = own_addr;
  assign bus_size  = own_size;
  assign bus_write = own_write & own_req;
  assign accept    = own_req & ~bus_pause;

  assign cpu_pause = bus_pause | (cpu_req & (owner != OWN_CPU));
  assign dma_pause = bus_pause | (dma_req & (owner != OWN_DMA));

  mem_arb_dphase u_dphase (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .accept_i    (accept),
    .owner_i     (owner),
    .write_i     (own_write),
    .bus_pause_i (bus_pause),
    .cpu_wdata_i (cpu_wdata),
    .dma_wdata_i (dma_wdata),
    .bus_rdata_i (bus_rdata),
    .bus_wdata_o (bus_wdata),
    .cpu_rdata_o (cpu_rdata),
    .dma_rdata_o (dma_rdata)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level reference model. Honours MEM_ARB_FAIR_EN.
module tb_mem_bus_arbiter;

  localparam int Burst = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req, dma_req, cpu_write, dma_write, dma_lock, bus_pause;
  logic [31:0] cpu_addr, dma_addr, cpu_wdata, dma_wdata, bus_rdata;
  logic [1:0]  cpu_size, dma_size;
  logic        cpu_pause, dma_pause, bus_write;
  logic [31:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata;
  logic [1:0]  bus_size;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: who held the address phase last cycle, whether that
  // cycle was frozen, the pending data phase, and the DMA run length.
  int m_grant, m_cur;
  bit m_hold, m_dv, m_dwr;
  int m_dow, m_cnt;

  mem_bus_arbiter #(.DMA_MAX_BURST(Burst)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .cpu_addr  (cpu_addr),
    .dma_addr  (dma_addr),
    .cpu_size  (cpu_size),
    .dma_size  (dma_size),
    .cpu_write (cpu_write),
    .dma_write (dma_write),
    .cpu_wdata (cpu_wdata),
    .dma_wdata (dma_wdata),
    .dma_lock  (dma_lock),
    .cpu_pause (cpu_pause),
    .dma_pause (dma_pause),
    .cpu_rdata (cpu_rdata),
    .dma_rdata (dma_rdata),
    .bus_addr  (bus_addr),
    .bus_size  (bus_size),
    .bus_write (bus_write),
    .bus_wdata (bus_wdata),
    .bus_pause (bus_pause),
    .bus_rdata (bus_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    m_grant = 0; m_hold = 0; m_dv = 0; m_dow = 0; m_dwr = 0; m_cnt = 0; m_cur = 0;
  endfunction

  // 0 = none, 1 = CPU, 2 = DMA
  function automatic int m_owner();
    if (!reset_n) return 0;
    if (m_hold) return m_grant;
    if (dma_lock && m_grant == 2) return 2;
`ifdef MEM_ARB_FAIR_EN
    if (m_cnt >= Burst && cpu_req && !dma_lock) return 1;
`endif
    if (dma_req) return 2;
    if (cpu_req) return 1;
    return 0;
  endfunction

  function automatic bit req_of(input int o);
    return (o == 1) ? cpu_req : (o == 2) ? dma_req : 1'b0;
  endfunction

  function automatic bit wr_of(input int o);
    return (o == 1) ? cpu_write : (o == 2) ? dma_write : 1'b0;
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic model_check();
    logic [31:0] e_addr, e_wd, e_crd, e_drd;
    logic [1:0]  e_size;
    bit          e_wr, e_cp, e_dp;
    int          o;
    o      = m_owner();
    m_cur  = o;
    e_addr = (o == 1) ? cpu_addr : (o == 2) ? dma_addr : 32'd0;
    e_size = (o == 1) ? cpu_size : (o == 2) ? dma_size : 2'd2;
    e_wr   = req_of(o) && wr_of(o);
    e_cp   = bus_pause || (cpu_req && o != 1);
    e_dp   = bus_pause || (dma_req && o != 2);
    e_wd   = (m_dv && m_dwr) ? ((m_dow == 1) ? cpu_wdata : dma_wdata) : 32'd0;
    e_crd  = (m_dv && !m_dwr && m_dow == 1) ? bus_rdata : 32'd0;
    e_drd  = (m_dv && !m_dwr && m_dow == 2) ? bus_rdata : 32'd0;
    check("bus_addr", bus_addr, e_addr);
    check("bus_size", {30'd0, bus_size}, {30'd0, e_size});
    check("bus_write", {31'd0, bus_write}, {31'd0, e_wr});
    check("bus_wdata", bus_wdata, e_wd);
    check("cpu_rdata", cpu_rdata, e_crd);
    check("dma_rdata", dma_rdata, e_drd);
    check("cpu_pause", {31'd0, cpu_pause}, {31'd0, e_cp});
    check("dma_pause", {31'd0, dma_pause}, {31'd0, e_dp});
  endtask

  task automatic sample();
    @(negedge clock);
    model_check();
  endtask

  // Advance one clock and update the model with what the edge committed.
  task automatic tick();
    bit acc;
    acc = (m_cur != 0) && req_of(m_cur) && !bus_pause;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      m_clear();
    end else begin
      if (!bus_pause) begin
        m_dv = acc;
        if (acc) begin
          m_dow = m_cur;
          m_dwr = wr_of(m_cur);
        end
      end
      if (acc && m_cur == 1) m_cnt = 0;
      else if (acc && m_cur == 2 && m_cnt < Burst) m_cnt++;
      m_hold  = bus_pause;
      m_grant = m_cur;
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; dma_req = 0; cpu_write = 0; dma_write = 0; dma_lock = 0; bus_pause = 0;
    cpu_addr = 0; dma_addr = 0; cpu_wdata = 0; dma_wdata = 0; bus_rdata = 0;
    cpu_size = 2'd2; dma_size = 2'd2;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    @(posedge clock);
    #1;
    reset_n = 1;
    m_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held_addr, held_wd;
    bit          exp_cpu;
    m_clear();
    reset_n = 0;
    idle_inputs();
    cpu_req = 1;
    #2;
    // Reset values with a pending CPU request.
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_size", {30'd0, bus_size}, 32'd2);
    check("rst_bus_write", {31'd0, bus_write}, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_rdata", dma_rdata, 32'd0);
    check("rst_cpu_pause", {31'd0, cpu_pause}, 32'd1);
    check("rst_dma_pause", {31'd0, dma_pause}, 32'd0);
    do_reset();

    // CPU write then read back, no pause.
    cpu_req = 1; cpu_write = 1; cpu_addr = 32'h0300_0010; cpu_size = 2'd2;
    sample();
    check("wr_bus_write", {31'd0, bus_write}, 32'd1);
    tick();
    cpu_write = 0; cpu_wdata = 32'hdead_beef;
    sample();
    check("wr_wdata", bus_wdata, 32'hdead_beef);
    tick();
    cpu_req = 0; cpu_wdata = 0; bus_rdata = 32'hdead_beef;
    sample();
    check("rd_cpu_rdata", cpu_rdata, 32'hdead_beef);
    check("rd_dma_rdata", dma_rdata, 32'd0);
    tick();

    // Simultaneous requests: DMA first, CPU the following cycle.
    idle_inputs();
    cpu_req = 1; cpu_addr = 32'h0600_0000;
    dma_req = 1; dma_write = 1; dma_addr = 32'h0500_0042; dma_size = 2'd1;
    sample();
    check("tie_addr", bus_addr, 32'h0500_0042);
    check("tie_cpu_pause", {31'd0, cpu_pause}, 32'd1);
    tick();
    dma_req = 0; dma_wdata = 32'h1234_5678;
    sample();
    check("tie2_addr", bus_addr, 32'h0600_0000);
    check("tie2_dma_pause", {31'd0, dma_pause}, 32'd0);
    check("tie2_wdata", bus_wdata, 32'h1234_5678);
    tick();

    // bus_pause held three cycles mid DMA burst.
    idle_inputs();
    cpu_req = 1; dma_req = 1; dma_write = 1; dma_addr = 32'h0500_0100;
    sample();
    tick();
    dma_addr = 32'h0500_0104; dma_wdata = 32'haaaa_0001; bus_pause = 1;
    sample();
    held_addr = bus_addr;
    held_wd   = bus_wdata;
    tick();
    for (int i = 0; i < 2; i++) begin
      sample();
      check("pause_addr", bus_addr, held_addr);
      check("pause_wdata", bus_wdata, held_wd);
      check("pause_dma", {31'd0, dma_pause}, 32'd1);
      check("pause_cpu", {31'd0, cpu_pause}, 32'd1);
      tick();
    end
    bus_pause = 0;
    sample();
    tick();

    // Lock held through a two-cycle DMA gap.
    do_reset();
    cpu_req = 1; dma_req = 1; dma_lock = 1; dma_write = 1; dma_addr = 32'h0500_0200;
    sample();
    tick();
    dma_req = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("lock_bus_write", {31'd0, bus_write}, 32'd0);
      check("lock_cpu_pause", {31'd0, cpu_pause}, 32'd1);
      tick();
    end
    dma_lock = 0;
    sample();
    check("unlock_cpu_pause", {31'd0, cpu_pause}, 32'd0);
    tick();

    // Continuous contention: fairness inserts a CPU slot every Burst DMA transfers.
    do_reset();
    cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 12; i++) begin
`ifdef MEM_ARB_FAIR_EN
      exp_cpu = ((i % (Burst + 1)) == Burst);
`else
      exp_cpu = 0;
`endif
      sample();
      check("fair_cpu_owner", {31'd0, dma_pause}, {31'd0, exp_cpu});
      tick();
    end

    // Reset pulsed during a paused CPU write.
    do_reset();
    cpu_req = 1; cpu_write = 1; cpu_addr = 32'h0300_0020;
    sample();
    tick();
    cpu_wdata = 32'hcafe_f00d; bus_pause = 1;
    sample();
    tick();
    #2;
    reset_n = 0;
    #1;
    check("mrst_bus_addr", bus_addr, 32'd0);
    check("mrst_bus_write", {31'd0, bus_write}, 32'd0);
    check("mrst_bus_wdata", bus_wdata, 32'd0);
    check("mrst_bus_size", {30'd0, bus_size}, 32'd2);
    check("mrst_cpu_pause", {31'd0, cpu_pause}, 32'd1);
    m_clear();
    sample();
    tick();
    reset_n = 1;
    bus_pause = 0; cpu_write = 0; dma_req = 1;
    sample();
    check("post_rst_dma_grant", {31'd0, dma_pause}, 32'd0);
    check("post_rst_wdata", bus_wdata, 32'd0);
    tick();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cpu_req   = ($urandom_range(0, 99) < 60);
      dma_req   = ($urandom_range(0, 99) < 50);
      cpu_write = $urandom_range(0, 1) == 1;
      dma_write = $urandom_range(0, 1) == 1;
      dma_lock  = ($urandom_range(0, 99) < 20);
      bus_pause = ($urandom_range(0, 99) < 25);
      cpu_addr  = $urandom;
      dma_addr  = $urandom;
      cpu_size  = 2'($urandom_range(0, 2));
      dma_size  = 2'($urandom_range(0, 2));
      cpu_wdata = $urandom;
      dma_wdata = $urandom;
      bus_rdata = $urandom;
      sample();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
